// File: rtl/csa_dot_accum_resolve_pkg.sv
// Shared types and default geometry for the carry-save dot-product accumulator.
package csa_dot_accum_resolve_pkg;

  localparam int unsigned DEF_IN_W    = 14;
  localparam int unsigned DEF_ACC_W   = 24;
  localparam int unsigned DEF_CHUNK_W = 8;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } state_e;

  function automatic int unsigned nchunk(input int unsigned acc_w, input int unsigned chunk_w);
    return acc_w / chunk_w;
  endfunction

endpackage

// File: rtl/csa_dot_accum_resolve_compress.sv
// Combinational 4:2 compressor built from two 3:2 rows; MSB carries that fall off
// the top of the word are reported separately so the caller can flag overflow.
module csa_4to2_compress #(
  parameter int unsigned W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry,
  output logic [1:0]   drop
);

  logic [W-1:0] s1_s;
  logic [W-1:0] maj1_s;
  logic [W-1:0] c1_s;
  logic [W-1:0] maj2_s;

  // two cascaded 3:2 rows
  always_comb begin
    s1_s   = a ^ b ^ c;
    maj1_s = (a & b) | (a & c) | (b & c);
    c1_s   = {maj1_s[W-2:0], 1'b0};
    sum    = s1_s ^ c1_s ^ d;
    maj2_s = (s1_s & c1_s) | (s1_s & d) | (c1_s & d);
    carry  = {maj2_s[W-2:0], 1'b0};
    drop   = {maj2_s[W-1], maj1_s[W-1]};
  end

endmodule

// File: rtl/csa_dot_accum_resolve.sv
// Accumulates (sum, carry) beats in carry-save form and resolves each group with a
// chunked multi-cycle CPA, presenting the binary result over valid/ready.
module csa_dot_accum_resolve
  import csa_dot_accum_resolve_pkg::*;
#(
  parameter int unsigned IN_W    = DEF_IN_W,
  parameter int unsigned ACC_W   = DEF_ACC_W,
  parameter int unsigned CHUNK_W = DEF_CHUNK_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic [IN_W-1:0]  in_carry,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int unsigned NCHUNK = nchunk(ACC_W, CHUNK_W);
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned BW     = $clog2(ACC_W);
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  if (((ACC_W % CHUNK_W) != 0) || (ACC_W < IN_W + 1)) begin : g_param_check
    $error("csa_dot_accum_resolve: ACC_W must be a multiple of CHUNK_W and >= IN_W+1");
  end

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_s_q, acc_s_d;
  logic [ACC_W-1:0]  acc_c_q, acc_c_d;
  logic              ovf_q, ovf_d;
  logic [KW-1:0]     k_q, k_d;
  logic              cin_q, cin_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;

  logic [ACC_W-1:0]  in_sum_ext_s;
  logic [ACC_W-1:0]  in_carry_ext_s;
  logic [ACC_W-1:0]  cmp_sum_s;
  logic [ACC_W-1:0]  cmp_carry_s;
  logic [1:0]        cmp_drop_s;
  logic [BW-1:0]     base_s;
  logic [CHUNK_W-1:0] chunk_s_s;
  logic [CHUNK_W-1:0] chunk_c_s;
  logic [CHUNK_W:0]  chunk_res_s;

  assign in_sum_ext_s   = {{(ACC_W-IN_W){1'b0}}, in_sum};
  assign in_carry_ext_s = {{(ACC_W-IN_W){1'b0}}, in_carry};

  csa_4to2_compress #(.W(ACC_W)) u_compress (
    .a     (acc_s_q),
    .b     (acc_c_q),
    .c     (in_sum_ext_s),
    .d     (in_carry_ext_s),
    .sum   (cmp_sum_s),
    .carry (cmp_carry_s),
    .drop  (cmp_drop_s)
  );

  // current CPA chunk slice and its ripple result
  always_comb begin
    base_s      = BW'(k_q) * BW'(CHUNK_W);
    chunk_s_s   = acc_s_q[base_s +: CHUNK_W];
    chunk_c_s   = acc_c_q[base_s +: CHUNK_W];
    chunk_res_s = {1'b0, chunk_s_s} + {1'b0, chunk_c_s} + {{CHUNK_W{1'b0}}, cin_q};
  end

  // next-state and datapath update
  always_comb begin
    state_d     = state_q;
    acc_s_d     = acc_s_q;
    acc_c_d     = acc_c_q;
    ovf_d       = ovf_q;
    k_d         = k_q;
    cin_d       = cin_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      ACCUM: begin
        if (in_valid && in_ready_q) begin
          acc_s_d = cmp_sum_s;
          acc_c_d = cmp_carry_s;
          ovf_d   = ovf_q | (|cmp_drop_s);
          if (in_last) begin
            state_d    = RESOLVE;
            k_d        = {KW{1'b0}};
            cin_d      = 1'b0;
            in_ready_d = 1'b0;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      RESOLVE: begin
        out_data_d[base_s +: CHUNK_W] = chunk_res_s[CHUNK_W-1:0];
        cin_d = chunk_res_s[CHUNK_W];
        if (k_q == K_LAST) begin
          ovf_d       = ovf_q | chunk_res_s[CHUNK_W];
          out_ovf_d   = ovf_q | chunk_res_s[CHUNK_W];
          out_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          k_d = k_q + {{(KW-1){1'b0}}, 1'b1};
        end
      end
      OUT: begin
        if (out_ready) begin
          acc_s_d     = {ACC_W{1'b0}};
          acc_c_d     = {ACC_W{1'b0}};
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ACCUM;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d     = ACCUM;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_s_q     <= {ACC_W{1'b0}};
      acc_c_q     <= {ACC_W{1'b0}};
      ovf_q       <= 1'b0;
      k_q         <= {KW{1'b0}};
      cin_q       <= 1'b0;
      out_data_q  <= {ACC_W{1'b0}};
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_s_q     <= acc_s_d;
      acc_c_q     <= acc_c_d;
      ovf_q       <= ovf_d;
      k_q         <= k_d;
      cin_q       <= cin_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_csa_dot_accum_resolve.sv
// Randomized bench for csa_dot_accum_resolve against an integer group-sum model.
module tb_csa_dot_accum_resolve;

  localparam int IN_W  = 14;
  localparam int ACC_W = 24;

  typedef struct packed {
    logic [ACC_W-1:0] d;
    logic             o;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_sum;
  logic [IN_W-1:0]  in_carry;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  longint unsigned grp_sum = 0;
  res_t exp_q[$];

  csa_dot_accum_resolve dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference: group value is the plain integer sum of all beats
  task automatic model_accept(input logic [IN_W-1:0] s, input logic [IN_W-1:0] c, input logic l);
    res_t r;
    grp_sum += longint'(s) + longint'(c);
    if (l) begin
      r.d = grp_sum[ACC_W-1:0];
      r.o = (grp_sum >= (64'd1 << ACC_W));
      exp_q.push_back(r);
      grp_sum = 0;
    end
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic beat(input logic [IN_W-1:0] s, input logic [IN_W-1:0] c, input logic l);
    int w = 0;
    in_sum = s; in_carry = c; in_last = l; in_valid = 1'b1;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check_val("beat_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
      model_accept(s, c, l);
    end
  endtask

  task automatic collect(input int hold, input bit chk_lat);
    int w = 0;
    res_t e;
    logic [ACC_W-1:0] d0;
    logic o0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (chk_lat) check_val("latency", 32'(w), 32'd3);
    check_val("out_valid", 32'(out_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check_val("exp_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val("out_data", 32'(out_data), 32'(e.d));
      check_val("out_ovf", 32'(out_ovf), 32'(e.o));
    end
    d0 = out_data; o0 = out_ovf;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_sum = 14'h0100; in_carry = 14'h0000; in_last = 1'b1;
      @(negedge clk);
      check_val("hold_data", 32'(out_data), 32'(d0));
      check_val("hold_ovf", 32'(out_ovf), 32'(o0));
      check_val("hold_valid", 32'(out_valid), 32'd1);
      check_val("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val("post_valid", 32'(out_valid), 32'd0);
    check_val("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  // continuous stream: driver keeps in_valid high, monitor drains results
  task automatic stream(input int ngroups, input int maxn, input bit rand_ready);
    int nres = ngroups;
    int got = 0;
    fork
      begin : driver
        for (int g = 0; g < ngroups; g++) begin
          int n = (maxn > 1) ? int'($urandom_range(1, maxn)) : 1;
          for (int b = 0; b < n; b++) begin
            logic [IN_W-1:0] s = IN_W'($urandom);
            logic [IN_W-1:0] c = IN_W'($urandom);
            logic l = (b == n - 1);
            logic acc;
            int w = 0;
            in_sum = s; in_carry = c; in_last = l; in_valid = 1'b1;
            do begin
              acc = in_ready;
              @(negedge clk);
              w++;
            end while (!acc && w < 200);
            if (acc) model_accept(s, c, l);
            else check_val("stream_beat_wait", 32'(acc), 32'd1);
          end
        end
        in_valid = 1'b0;
      end
      begin : monitor
        int w = 0;
        int last_hs = -1;
        bit waiting = 1'b0;
        logic [ACC_W-1:0] held_d = '0;
        logic held_o = 1'b0;
        res_t e;
        while (got < nres && w < 5000) begin
          out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          if (waiting && out_valid) begin
            check_val("stream_hold_data", 32'(out_data), 32'(held_d));
            check_val("stream_hold_ovf", 32'(out_ovf), 32'(held_o));
          end
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              check_val("stream_exp_empty", 32'(exp_q.size()), 32'd1);
            end else begin
              e = exp_q.pop_front();
              check_val("stream_data", 32'(out_data), 32'(e.d));
              check_val("stream_ovf", 32'(out_ovf), 32'(e.o));
            end
            if (!rand_ready && last_hs >= 0) check_val("stream_period", 32'(cyc - last_hs), 32'd5);
            last_hs = cyc;
            got++;
            waiting = 1'b0;
          end else begin
            waiting = out_valid;
            held_d = out_data;
            held_o = out_ovf;
          end
          @(negedge clk);
          w++;
        end
        out_ready = 1'b0;
        check_val("stream_count", 32'(got), 32'(nres));
      end
    join
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_carry = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_data", 32'(out_data), 32'd0);
    check_val("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single beat 0x3FF + 0x001
    beat(14'h03FF, 14'h0001, 1'b1);
    collect(0, 1'b1);

    // four saturated beats
    for (int i = 0; i < 4; i++) beat(14'h3FFF, 14'h3FFF, 1'(i == 3));
    collect(0, 1'b1);

    // back-pressure with in_valid asserted
    beat(14'h1234, 14'h0567, 1'b1);
    collect(5, 1'b1);

    // overflow group, then a clean group
    for (int i = 0; i < 600; i++) beat(14'h3FFF, 14'h3FFF, 1'(i == 599));
    collect(0, 1'b1);
    beat(14'h0001, 14'h0002, 1'b1);
    collect(0, 1'b1);

    // reset in the middle of resolve
    beat(14'h0003, 14'h0004, 1'b0);
    beat(14'h0005, 14'h0006, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    grp_sum = 0;
    check_val("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_mid_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    beat(14'h0005, 14'h0003, 1'b1);
    collect(0, 1'b1);

    // back-to-back single-beat groups, then random group sizes with random back-pressure
    stream(20, 1, 1'b0);
    @(negedge clk);
    stream(30, 8, 1'b1);
    repeat (2) @(negedge clk);
    check_val("exp_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
